// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RV32I control FSM with timed memory handshake and trap entry
module mc_control_fsm #(
  parameter int MEM_TIMEOUT  = 15,
  parameter int ALU_LAT      = 0,
  parameter bit HALT_ON_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mem_ready,
  input  logic       branch,
  input  logic [6:0] opcode,
  output logic       cede,
  output logic       rf_we,
  output logic       pc_we,
  output logic       prev_pc_we,
  output logic       rs1_we,
  output logic       rs2_we,
  output logic       alu_we,
  output logic       instr_we,
  output logic       mem_req,
  output logic       mem_ad_sel,
  output logic [1:0] a_sel,
  output logic [1:0] b_sel,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_op,
  output logic [1:0] mem_op,
  output logic [2:0] wd_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] cpu_state
);
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_ALUWAIT = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWR   = 4'd6,
    S_WB      = 4'd7,
    S_TRAP    = 4'd8
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] ALU_LAST = 8'(ALU_LAT - 1);
  localparam bit         ALU_WAIT = (ALU_LAT > 0);

  state_t     state, state_next, boundary;
  logic [7:0] cnt, cnt_next;
  logic [1:0] cause_q, cause_next;
  logic       mem_expired, op_imm, legal;

  assign boundary    = run ? S_FETCH : S_IDLE;
  assign mem_expired = (cnt == MEM_LAST);
  assign op_imm      = (opcode == OPC_OPIMM);
  assign trap_cause  = cause_q;
  assign cpu_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cause_q <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      cause_q <= cause_next;
    end
  end

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cause_next = cause_q;
    cede       = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    prev_pc_we = 1'b0;
    rs1_we     = 1'b0;
    rs2_we     = 1'b0;
    alu_we     = 1'b0;
    instr_we   = 1'b0;
    mem_req    = 1'b0;
    mem_ad_sel = 1'b0;
    a_sel      = 2'd0;
    b_sel      = 2'd0;
    pc_sel     = 2'd0;
    alu_op     = 2'd0;
    mem_op     = 2'd0;
    wd_sel     = 3'd0;
    trap       = 1'b0;

    case (state)
      S_IDLE: begin
        cede = 1'b1;
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        mem_op  = 2'd1;
        if (mem_ready) begin
          instr_we   = 1'b1;
          prev_pc_we = 1'b1;
          pc_we      = 1'b1;
          a_sel      = 2'd1;
          b_sel      = 2'd2;
          state_next = S_DECODE;
        end else if (mem_expired) begin
          state_next = S_TRAP;
          cause_next = 2'd3;
        end
      end
      S_DECODE: begin
        rs1_we = 1'b1;
        rs2_we = 1'b1;
        alu_we = 1'b1;
        a_sel  = 2'd2;
        b_sel  = 2'd1;
        if (!legal || opcode == OPC_SYSTEM) begin
          state_next = S_TRAP;
          cause_next = (opcode == OPC_SYSTEM) ? 2'd1 : 2'd0;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OPC_LUI, OPC_AUIPC: state_next = S_WB;
          OPC_JAL: begin
            pc_we      = 1'b1;
            pc_sel     = 2'd1;
            state_next = S_WB;
          end
          OPC_JALR: begin
            alu_we     = 1'b1;
            b_sel      = 2'd1;
            state_next = S_WB;
          end
          OPC_BRANCH: begin
            alu_op = 2'd1;
            if (branch) begin
              pc_we  = 1'b1;
              pc_sel = 2'd1;
            end
            state_next = boundary;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_we     = 1'b1;
            b_sel      = 2'd1;
            state_next = (opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
          end
          OPC_OP, OPC_OPIMM: begin
            alu_op = 2'd2;
            b_sel  = op_imm ? 2'd1 : 2'd0;
            if (ALU_WAIT) begin
              state_next = S_ALUWAIT;
            end else begin
              alu_we     = 1'b1;
              state_next = S_WB;
            end
          end
          default: state_next = boundary;
        endcase
      end
      S_ALUWAIT: begin
        alu_op = 2'd2;
        b_sel  = op_imm ? 2'd1 : 2'd0;
        if (cnt == ALU_LAST) begin
          alu_we     = 1'b1;
          state_next = S_WB;
        end
      end
      S_MEMRD, S_MEMWR: begin
        mem_req    = 1'b1;
        mem_ad_sel = 1'b1;
        mem_op     = (state == S_MEMRD) ? 2'd2 : 2'd3;
        if (mem_ready) begin
          state_next = (state == S_MEMRD) ? S_WB : boundary;
        end else if (mem_expired) begin
          state_next = S_TRAP;
          cause_next = 2'd3;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        case (opcode)
          OPC_LOAD:          wd_sel = 3'd1;
          OPC_LUI:           wd_sel = 3'd2;
          OPC_JAL, OPC_JALR: wd_sel = 3'd3;
          default:           wd_sel = 3'd0;
        endcase
        // JALR commits its rs1+imm target here, after the link value is taken
        if (opcode == OPC_JALR) pc_we = 1'b1;
        state_next = boundary;
      end
      S_TRAP: begin
        trap       = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = 2'd2;
        state_next = HALT_ON_TRAP ? S_IDLE : S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end else if (state == S_FETCH || state == S_MEMRD || state == S_MEMWR || state == S_ALUWAIT) begin
      cnt_next = cnt + 8'd1;
    end
  end
endmodule
